// File: rtl/wb_port_arbiter_pkg.sv
// Shared configuration and types for the register-file write-back arbiter.
// The localparams here are the single point where the port geometry is set.
package wb_port_arbiter_pkg;
  localparam int DATA_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int FREE_LIST_WIDTH = 3;
  localparam int NUM_REQ         = 3;
  localparam int REQ_IDX_WIDTH   = $clog2(NUM_REQ);
  localparam int PADDR_WIDTH     = REG_ADDR_WIDTH + 1;

  // Active level of the register_file write strobe.
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [REQ_IDX_WIDTH-1:0] {
    WB_REQ_ALU = REQ_IDX_WIDTH'(0),
    WB_REQ_LSU = REQ_IDX_WIDTH'(1),
    WB_REQ_MUL = REQ_IDX_WIDTH'(2)
  } wb_req_e;

  typedef struct packed {
    logic [PADDR_WIDTH-1:0]     paddr;
    logic [PADDR_WIDTH-1:0]     vaddr;
    logic [DATA_WIDTH-1:0]      data;
    logic [FREE_LIST_WIDTH-1:0] alidx;
  } wb_payload_t;

  function automatic logic [REQ_IDX_WIDTH-1:0] next_rr_ptr(input logic [REQ_IDX_WIDTH-1:0] idx);
    return (idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester-side and register_file-side signals of the write-back arbiter.
// master = execution units / register_file side, slave = the arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                               wb_hold;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ*PADDR_WIDTH-1:0]     req_paddr;
  logic [NUM_REQ*PADDR_WIDTH-1:0]     req_vaddr;
  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data;
  logic [NUM_REQ*FREE_LIST_WIDTH-1:0] req_alidx;
  logic                               mem_write_enable;
  logic [PADDR_WIDTH-1:0]             wb_physical_write_addr;
  logic [PADDR_WIDTH-1:0]             wb_virtual_write_addr;
  logic [DATA_WIDTH-1:0]              wb_physical_write_data;
  logic [FREE_LIST_WIDTH-1:0]         wb_active_list_index;
  logic [REQ_IDX_WIDTH-1:0]           wb_grant_id;
  logic                               stall_out;

  modport master (
    output wb_hold, req_valid, req_paddr, req_vaddr, req_data, req_alidx,
    input  req_ready, mem_write_enable, wb_physical_write_addr, wb_virtual_write_addr,
           wb_physical_write_data, wb_active_list_index, wb_grant_id, stall_out
  );

  modport slave (
    input  wb_hold, req_valid, req_paddr, req_vaddr, req_data, req_alidx,
    output req_ready, mem_write_enable, wb_physical_write_addr, wb_virtual_write_addr,
           wb_physical_write_data, wb_active_list_index, wb_grant_id, stall_out
  );
endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping.
// 'any' reports a candidate exists regardless of en; grant is gated by en.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    // Scan from farthest to nearest so the nearest valid candidate is written last.
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (valid[idx]) begin
        grant_idx = idx;
        any       = 1'b1;
      end
    end
    if (any && en) begin
      grant = N'(1) << grant_idx;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register_file write-back port among execution units.
// The winner's payload is registered for one cycle; zero physical address suppresses the strobe.
module wb_port_arbiter (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  import wb_port_arbiter_pkg::*;

  wb_payload_t              payload [NUM_REQ];
  wb_payload_t              win_pl;
  logic [NUM_REQ-1:0]       grant;
  logic [REQ_IDX_WIDTH-1:0] win_idx;
  logic                     win_any;
  logic                     grant_en;
  logic                     xfer;

  logic                     we_q, we_d;
  wb_payload_t              pl_q, pl_d;
  logic [REQ_IDX_WIDTH-1:0] gid_q, gid_d;
  logic [REQ_IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic                     stall_q, stall_d;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign payload[gi] = {bus.req_paddr[gi*PADDR_WIDTH +: PADDR_WIDTH],
                          bus.req_vaddr[gi*PADDR_WIDTH +: PADDR_WIDTH],
                          bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH],
                          bus.req_alidx[gi*FREE_LIST_WIDTH +: FREE_LIST_WIDTH]};
  end

  // No grants while held or while reset is asserted.
  assign grant_en = rst_n & ~bus.wb_hold;

  rr_arbiter #(.N(NUM_REQ), .IW(REQ_IDX_WIDTH)) u_rr (
    .valid     (bus.req_valid),
    .ptr       (ptr_q),
    .en        (grant_en),
    .grant     (grant),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign bus.req_ready = grant;
  assign xfer          = win_any & grant_en;
  assign win_pl        = payload[win_idx];

  always_comb begin
    we_d    = ~MEM_WRITE;
    pl_d    = pl_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    stall_d = |(bus.req_valid & ~grant);
    if (xfer) begin
      we_d  = (win_pl.paddr != '0) ? MEM_WRITE : ~MEM_WRITE;
      pl_d  = win_pl;
      gid_d = win_idx;
      ptr_d = next_rr_ptr(win_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= ~MEM_WRITE;
      pl_q    <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      pl_q    <= pl_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
    end
  end

  assign bus.mem_write_enable       = we_q;
  assign bus.wb_physical_write_addr = pl_q.paddr;
  assign bus.wb_virtual_write_addr  = pl_q.vaddr;
  assign bus.wb_physical_write_data = pl_q.data;
  assign bus.wb_active_list_index   = pl_q.alidx;
  assign bus.wb_grant_id            = gid_q;
  assign bus.stall_out              = stall_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a queue-free behavioural model checked every
// cycle on the falling edge, plus literal expectations for each scenario.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int N  = NUM_REQ;
  localparam int PW = PADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int FW = FREE_LIST_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_req(input int i, input logic [PW-1:0] pa, input logic [PW-1:0] va,
                         input logic [DW-1:0] d, input logic [FW-1:0] ai);
    bus.req_paddr[i*PW +: PW] = pa;
    bus.req_vaddr[i*PW +: PW] = va;
    bus.req_data[i*DW +: DW]  = d;
    bus.req_alidx[i*FW +: FW] = ai;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model state: what the registered outputs must show after the next edge.
  int             m_ptr;
  int             m_gid;
  int             win;
  int             j;
  logic           m_we;
  logic           m_stall;
  logic [PW-1:0]  m_pa, m_va;
  logic [DW-1:0]  m_d;
  logic [FW-1:0]  m_ai;
  logic [N-1:0]   exp_ready;

  initial begin
    m_ptr = 0; m_gid = 0; m_we = 1'b0; m_stall = 1'b0;
    m_pa = '0; m_va = '0; m_d = '0; m_ai = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_gid = 0; m_we = 1'b0; m_stall = 1'b0;
        m_pa = '0; m_va = '0; m_d = '0; m_ai = '0;
      end
      chk("mem_write_enable", 64'(bus.mem_write_enable), 64'(m_we));
      chk("wb_physical_write_addr", 64'(bus.wb_physical_write_addr), 64'(m_pa));
      chk("wb_virtual_write_addr", 64'(bus.wb_virtual_write_addr), 64'(m_va));
      chk("wb_physical_write_data", 64'(bus.wb_physical_write_data), 64'(m_d));
      chk("wb_active_list_index", 64'(bus.wb_active_list_index), 64'(m_ai));
      chk("wb_grant_id", 64'(bus.wb_grant_id), 64'(m_gid));
      chk("stall_out", 64'(bus.stall_out), 64'(m_stall));

      win = -1;
      if (rst_n && !bus.wb_hold) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (win < 0 && |((bus.req_valid >> j) & N'(1))) win = j;
        end
      end
      exp_ready = (win >= 0) ? (N'(1) << win) : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));

      if (rst_n) begin
        m_stall = |(bus.req_valid & ~exp_ready);
        if (win >= 0) begin
          m_pa  = PW'(bus.req_paddr >> (win * PW));
          m_va  = PW'(bus.req_vaddr >> (win * PW));
          m_d   = DW'(bus.req_data >> (win * DW));
          m_ai  = FW'(bus.req_alidx >> (win * FW));
          m_we  = (m_pa != '0);
          m_gid = win;
          m_ptr = (win + 1) % N;
          $display("xfer req%0d paddr=%h vaddr=%h data=%h alidx=%0d", win, m_pa, m_va, m_d, m_ai);
        end else begin
          m_we = 1'b0;
        end
      end
    end
  end

  int order [6] = '{0, 1, 2, 0, 1, 2};
  logic [N-1:0] one = N'(1);

  initial begin
    bus.wb_hold   = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < N; i++) begin
      set_req(i, PW'(16 + i), PW'(8 + i), DW'(32'hA000_0000 + i), FW'(i + 1));
    end

    // Reset held with everyone valid: no grants, all outputs quiet.
    bus.req_valid = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_we", 64'(bus.mem_write_enable), 64'h0);
    end
    step();
    rst_n = 1'b1;

    // Round robin starting from requester 0.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", k), 64'(bus.req_ready), 64'(one << order[k]));
      if (k >= 1) chk($sformatf("rr_stall%0d", k), 64'(bus.stall_out), 64'h1);
    end

    // Single request from requester 1.
    step();
    set_req(1, 6'h21, 6'h01, 32'hDEADBEEF, 3'd3);
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'b010);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_we", 64'(bus.mem_write_enable), 64'h1);
    chk("single_addr", 64'(bus.wb_physical_write_addr), 64'h21);
    chk("single_data", 64'(bus.wb_physical_write_data), 64'hDEADBEEF);
    chk("single_alidx", 64'(bus.wb_active_list_index), 64'h3);
    chk("single_gid", 64'(bus.wb_grant_id), 64'h1);
    step();
    @(negedge clk);
    chk("single_we_off", 64'(bus.mem_write_enable), 64'h0);

    // Hold with all valid and rr_ptr at 2.
    step();
    bus.req_valid = 3'b111;
    bus.wb_hold   = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk($sformatf("hold_ready%0d", h), 64'(bus.req_ready), 64'h0);
      chk($sformatf("hold_we%0d", h), 64'(bus.mem_write_enable), 64'h0);
      if (h >= 1) chk($sformatf("hold_stall%0d", h), 64'(bus.stall_out), 64'h1);
    end
    step();
    bus.wb_hold = 1'b0;
    @(negedge clk);
    chk("hold_resume", 64'(bus.req_ready), 64'b100);

    // Zero physical address on requester 0.
    step();
    set_req(0, 6'h00, 6'h05, 32'h1234_5678, 3'd6);
    bus.req_valid = 3'b001;
    @(negedge clk);
    chk("zero_ready", 64'(bus.req_ready), 64'b001);
    step();
    set_req(0, 6'h10, 6'h08, 32'hA000_0000, 3'd1);
    bus.req_valid = 3'b011;
    @(negedge clk);
    chk("zero_we", 64'(bus.mem_write_enable), 64'h0);
    chk("zero_addr", 64'(bus.wb_physical_write_addr), 64'h0);
    chk("zero_data", 64'(bus.wb_physical_write_data), 64'h12345678);
    chk("zero_ptr_adv", 64'(bus.req_ready), 64'b010);

    // Reset asserted the cycle after requester 1's grant.
    step();
    bus.req_valid = '0;
    #1;
    chk("midrst_we_before", 64'(bus.mem_write_enable), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(bus.mem_write_enable), 64'h0);
    chk("midrst_addr", 64'(bus.wb_physical_write_addr), 64'h0);
    chk("midrst_gid", 64'(bus.wb_grant_id), 64'h0);
    step();
    rst_n = 1'b1;
    bus.req_valid = 3'b101;
    @(negedge clk);
    chk("midrst_ptr0", 64'(bus.req_ready), 64'b001);
    step();
    bus.req_valid = '0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
